imm_extend_unit: RTL
====================

Name: imm_extend_unit

Overview:
- Parametrised, registered immediate-extension stage for the five-stage MIPS pipeline. It sits between decode and the ID/EX register.
- Takes an IN_W-bit immediate plus a mode and produces an OUT_W-bit operand: sign-extended, zero-extended, upper-placed (LUI) or sign-extended-and-shifted (branch offset).
- A 2-entry output buffer with valid/ready handshakes on both sides absorbs one cycle of downstream stall without dropping data.
- An opaque TAG_W tag travels with each immediate, e.g. the destination register.

Parameters:
- IN_W, 16, immediate input width; must be ≥ 2.
- OUT_W, 32, extended output width; must be ≥ IN_W + SHIFT.
- SHIFT, 2, left shift applied in mode 3 (branch word offset).
- TAG_W, 5, width of the sideband tag carried with each entry.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_imm/in_mode/in_tag valid this cycle
- in_ready  out  1  unit can accept an entry this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 sign+shift
- in_tag  in  TAG_W  sideband tag, passed through unchanged
- out_valid  out  1  out_data/out_tag hold a valid entry
- out_ready  in  1  consumer takes the entry this cycle
- out_data  out  OUT_W  extended immediate
- out_tag  out  TAG_W  tag of the current output entry
- occupancy  out  2  number of buffered entries, 0..2

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: occupancy=0, out_valid=0, out_data=0, out_tag=0, in_ready=1 in the cycle after reset. Asserting reset mid-operation discards all buffered entries. An in_valid present in the reset cycle is not accepted.
- Extension is combinational on the input side; the result is written into the buffer at the accepting edge.
- mode 00: out = {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
- mode 01: out = {(OUT_W-IN_W){1'b0}, imm}.
- mode 10: out = imm << (OUT_W-IN_W); low bits are zero. Defaults give {imm,16'h0}.
- mode 11: out = sign-extended imm << SHIFT. The shift is applied after extension to OUT_W; no bits are lost given the OUT_W constraint.
- Accept: in_valid && in_ready at the rising edge. Pop: out_valid && out_ready at the rising edge.
- in_ready = (occupancy < 2); it depends only on registered state, never on out_ready.
- out_valid = (occupancy != 0). out_data/out_tag always present the oldest entry (head).
- Latency: an entry accepted at edge N is visible on out_data with out_valid=1 after edge N, when the buffer was empty before the push.
- Push only: occupancy +1. Pop only: occupancy −1; the second entry, if any, moves to head.
- Push and pop in the same cycle: occupancy unchanged. With occupancy=1, the new entry becomes head on the next cycle.
- Full (occupancy=2): in_ready=0, no push; a pop returns occupancy to 1.
- Empty: out_valid=0. An out_ready with no entry is ignored and occupancy stays 0.
- Stability: while out_valid=1 and out_ready=0, out_data/out_tag hold constant.
- Order: FIFO, no reordering, no duplication, no loss.
- Empty-state output: out_data/out_tag keep their last value. Verification checks them only when out_valid=1, except after reset, where they are 0.

Test Plan:
- Mode sweep, out_ready=1, defaults: 16'h8001 in mode 00/01/10/11 → 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, each one cycle after accept with tags intact.
- Positive boundary: 16'h7FFF in mode 00 → 32'h00007FFF; in mode 11 → 32'h0001FFFC.
- Backpressure: out_ready=0, push A=16'h0001, then B=16'h0002, then C.
  - in_ready drops after B; C is not accepted; occupancy=2.
  - out_data holds 32'h00000001.
  - Raising out_ready yields A, then B, in order; C is accepted once in_ready=1.
- Simultaneous push and pop at occupancy=1: occupancy stays 1 and the output sequence is unbroken, one entry per cycle for 8 back-to-back inputs.
- Reset mid-operation: with occupancy=2, assert reset for one cycle → occupancy=0, out_valid=0, out_data=0, in_ready=1. An in_valid during reset is not observed at the output.
- Parameter instance IN_W=12, OUT_W=32, SHIFT=1: 12'h800 in mode 11 → 32'hFFFFF000; in mode 10 → 32'h80000000.

Source files
------------

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// imm_extend_unit : registered MIPS immediate extender with 2-entry skid FIFO
// Revision 1.0
// ============================================================================
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  logic [1:0]       occ_q, occ_d;
  logic [OUT_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;

  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] ext_w;
  logic             push_w;
  logic             pop_w;

  assign sext_w = OUT_W'($signed(in_imm));

  always_comb begin
    ext_w = sext_w;
    unique case (in_mode)
      MODE_SIGN:  ext_w = sext_w;
      MODE_ZERO:  ext_w = OUT_W'(in_imm);
      MODE_UPPER: ext_w = OUT_W'(in_imm) << (OUT_W - IN_W);
      MODE_SHIFT: ext_w = sext_w << SHIFT;
      default:    ext_w = sext_w;
    endcase
  end

  assign in_ready  = (occ_q < 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = data0_q;
  assign out_tag   = tag0_q;
  assign occupancy = occ_q;

  assign push_w = in_valid && in_ready;
  assign pop_w  = out_valid && out_ready;

  // Slot 0 is always the head; slot 1 only ever holds the second entry.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    tag0_d  = tag0_q;
    data1_d = data1_q;
    tag1_d  = tag1_q;
    if (push_w && pop_w) begin
      data0_d = ext_w;
      tag0_d  = in_tag;
    end else if (push_w) begin
      occ_d = occ_q + 2'd1;
      if (occ_q == 2'd0) begin
        data0_d = ext_w;
        tag0_d  = in_tag;
      end else begin
        data1_d = ext_w;
        tag1_d  = in_tag;
      end
    end else if (pop_w) begin
      occ_d = occ_q - 2'd1;
      if (occ_q == 2'd2) begin
        data0_d = data1_q;
        tag0_d  = tag1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      tag0_q  <= '0;
      data1_q <= '0;
      tag1_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      tag0_q  <= tag0_d;
      data1_q <= data1_d;
      tag1_q  <= tag1_d;
    end
  end

endmodule
`default_nettype wire
